// File: rtl/song_editor_pkg.sv
// Shared definitions for the multi-lane song editor.
//   - state_t    : editor FSM states (EDIT, CLEAR)
//   - BTN_*      : bit positions of each button in the packed button vector
//   - init_bit() : looks up the reset/clear value of one step of one lane
package song_editor_pkg;

  typedef enum logic {
    EDIT  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int BTN_W0    = 0;
  localparam int BTN_W1    = 1;
  localparam int BTN_BACK  = 2;
  localparam int BTN_LANE  = 3;
  localparam int BTN_CLEAR = 4;
  localparam int NUM_BTNS  = 5;

  // Widest pattern the editor supports: 8 lanes x 64 steps.
  localparam int MAX_BITS  = 512;
  localparam int MAX_IDX_W = $clog2(MAX_BITS);

  // Lane k occupies bits [k*song_len +: song_len] of the pattern.
  function automatic logic init_bit(input logic [MAX_BITS-1:0] pattern,
                                    input int lane,
                                    input int step,
                                    input int song_len);
    logic [MAX_IDX_W-1:0] idx;
    idx = MAX_IDX_W'(lane * song_len + step);
    return pattern[idx];
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw
// push-button input.
//   clk   : system clock
//   nrst  : asynchronous active-low reset
//   din   : raw asynchronous button level
//   pulse : one-cycle high pulse on each synchronized rising edge
// Latency: din rising before clock edge N gives pulse high between edges
// N+1 and N+2. The pulse is driven only from flops.
module sync_edge_det (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift together;
      // blocking ones here would collapse the chain into a single stage.
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/song_editor_multi.sv
// Multi-lane note-pattern editor. NUM_LANES lanes of SONG_LEN steps each;
// one lane is selected at a time and every lane keeps its own write cursor.
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   btn_w0     : write 0 at cursor, advance
//   btn_w1     : write 1 at cursor, advance
//   btn_back   : step cursor back, restore INIT bit there
//   btn_lane   : select next lane (modulo NUM_LANES)
//   btn_clear  : sweep selected lane back to INIT (one step per cycle)
//   lanes      : all lane contents, lane k at [k*SONG_LEN +: SONG_LEN]
//   lane_sel   : selected lane
//   position   : cursor of the selected lane
//   lane_full  : per-lane sticky "last step written" flag
//   busy       : clear sweep in progress
// Button priority when pulses coincide: clear > lane > back > write.
module song_editor_multi
  import song_editor_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SONG_LEN  = 32,
  parameter int IDX_W     = $clog2(SONG_LEN),
  parameter bit WRAP      = 1'b1,
  parameter logic [NUM_LANES*SONG_LEN-1:0] INIT_PATTERN = {NUM_LANES{32'hCCCCCCCC}}
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          btn_w0,
  input  logic                          btn_w1,
  input  logic                          btn_back,
  input  logic                          btn_lane,
  input  logic                          btn_clear,
  output logic [NUM_LANES*SONG_LEN-1:0] lanes,
  output logic [$clog2(NUM_LANES)-1:0]  lane_sel,
  output logic [IDX_W-1:0]              position,
  output logic [NUM_LANES-1:0]          lane_full,
  output logic                          busy
);

  localparam int LSEL_W = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(SONG_LEN - 1);
  localparam logic [LSEL_W-1:0] LAST_LANE = LSEL_W'(NUM_LANES - 1);
  localparam logic [MAX_BITS-1:0] INIT_WIDE = MAX_BITS'(INIT_PATTERN);

  // ---------------------------------------------------------------- buttons
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_pulse;

  assign btn_raw = {btn_clear, btn_lane, btn_back, btn_w1, btn_w0};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    sync_edge_det u_det (
      .clk   (clk),
      .nrst  (nrst),
      .din   (btn_raw[g]),
      .pulse (btn_pulse[g])
    );
  end

  // ------------------------------------------------------------------ state
  state_t                        state;
  state_t                        state_nx;
  logic [NUM_LANES*SONG_LEN-1:0] lane_bits;
  logic [IDX_W-1:0]              cur [NUM_LANES];
  logic [LSEL_W-1:0]             sel;
  logic [NUM_LANES-1:0]          full;
  // Set when a WRAP=0 lane has written its last step; blocks further writes
  // until a back or clear moves the cursor off the end.
  logic [NUM_LANES-1:0]          sat;
  logic [IDX_W-1:0]              sweep;

  // ----------------------------------------------------------- decode (FSM)
  logic             do_clear;
  logic             do_lane;
  logic             do_back;
  logic             do_write;
  logic             write_val;
  logic             sweep_last;
  logic [IDX_W-1:0] cur_sel;
  logic             at_last;
  logic             back_en;
  logic [IDX_W-1:0] back_idx;
  logic             write_en;

  assign cur_sel = cur[sel];
  assign at_last = (cur_sel == LAST_STEP);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves one unassigned, which would infer a latch.
    state_nx   = state;
    do_clear   = 1'b0;
    do_lane    = 1'b0;
    do_back    = 1'b0;
    do_write   = 1'b0;
    write_val  = 1'b0;
    sweep_last = 1'b0;
    unique case (state)
      EDIT: begin
        if (btn_pulse[BTN_CLEAR]) begin
          do_clear = 1'b1;
          state_nx = CLEAR;
        end else if (btn_pulse[BTN_LANE]) begin
          do_lane = 1'b1;
        end else if (btn_pulse[BTN_BACK]) begin
          do_back = 1'b1;
        end else if (btn_pulse[BTN_W0] ^ btn_pulse[BTN_W1]) begin
          do_write  = 1'b1;
          write_val = btn_pulse[BTN_W1];
        end
      end
      CLEAR: begin
        if (sweep == LAST_STEP) begin
          sweep_last = 1'b1;
          state_nx   = EDIT;
        end
      end
      default: state_nx = EDIT;
    endcase
  end

  // Back from step 0 only moves when the lane has been filled and wraps.
  always_comb begin
    back_en  = 1'b0;
    back_idx = cur_sel - 1'b1;
    if (do_back) begin
      if (cur_sel != '0) begin
        back_en = 1'b1;
      end else if (WRAP && full[sel]) begin
        back_en  = 1'b1;
        back_idx = LAST_STEP;
      end
    end
  end

  assign write_en = do_write && !sat[sel];

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= EDIT;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: lane storage is a plain register array with a defined reset
      // image, not a RAM, so it is reset along with the control state.
      lane_bits <= INIT_PATTERN;
      for (int i = 0; i < NUM_LANES; i++) cur[i] <= '0;
      sel   <= '0;
      full  <= '0;
      sat   <= '0;
      sweep <= '0;
    end else begin
      if (do_clear) sweep <= '0;

      if (state == CLEAR) begin
        lane_bits[{sel, sweep}] <=
          init_bit(INIT_WIDE, int'(sel), int'(sweep), SONG_LEN);
        sweep <= sweep + 1'b1;
        if (sweep_last) begin
          cur[sel]  <= '0;
          full[sel] <= 1'b0;
          sat[sel]  <= 1'b0;
        end
      end

      if (do_lane) sel <= (sel == LAST_LANE) ? '0 : sel + 1'b1;

      if (back_en) begin
        cur[sel] <= back_idx;
        sat[sel] <= 1'b0;
        lane_bits[{sel, back_idx}] <=
          init_bit(INIT_WIDE, int'(sel), int'(back_idx), SONG_LEN);
      end

      if (write_en) begin
        lane_bits[{sel, cur_sel}] <= write_val;
        if (at_last) begin
          full[sel] <= 1'b1;
          if (WRAP) cur[sel] <= '0;
          else      sat[sel] <= 1'b1;
        end else begin
          cur[sel] <= cur_sel + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign lanes     = lane_bits;
  assign lane_sel  = sel;
  assign position  = cur_sel;
  assign lane_full = full;
  assign busy      = (state == CLEAR);

endmodule

// File: tb/tb_song_editor_multi.sv
// Self-checking bench for song_editor_multi: one wrapping and one
// saturating instance share the same button stimulus.
module tb_song_editor_multi;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_W0    = 5'b00001;
  localparam logic [4:0] B_W1    = 5'b00010;
  localparam logic [4:0] B_BACK  = 5'b00100;
  localparam logic [4:0] B_LANE  = 5'b01000;
  localparam logic [4:0] B_CLEAR = 5'b10000;

  localparam logic [31:0] LI  = 32'hCCCCCCCC;
  localparam logic [31:0] LD  = 32'hCCCCCCCD;
  localparam logic [31:0] LDD = 32'hCCCCCCDD;
  localparam logic [31:0] LZ  = 32'h00000000;
  localparam logic [31:0] L1  = 32'h00000001;

  logic clk = 1'b0;
  logic nrst;
  logic btn_w0, btn_w1, btn_back, btn_lane, btn_clear;

  logic [127:0] lanes_w, lanes_s;
  logic [1:0]   sel_w, sel_s;
  logic [4:0]   pos_w, pos_s;
  logic [3:0]   full_w, full_s;
  logic         busy_w, busy_s;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  song_editor_multi #(.WRAP(1'b1)) dut_wrap (
    .clk(clk), .nrst(nrst),
    .btn_w0(btn_w0), .btn_w1(btn_w1), .btn_back(btn_back),
    .btn_lane(btn_lane), .btn_clear(btn_clear),
    .lanes(lanes_w), .lane_sel(sel_w), .position(pos_w),
    .lane_full(full_w), .busy(busy_w)
  );

  song_editor_multi #(.WRAP(1'b0)) dut_sat (
    .clk(clk), .nrst(nrst),
    .btn_w0(btn_w0), .btn_w1(btn_w1), .btn_back(btn_back),
    .btn_lane(btn_lane), .btn_clear(btn_clear),
    .lanes(lanes_s), .lane_sel(sel_s), .position(pos_s),
    .lane_full(full_s), .busy(busy_s)
  );

  typedef struct {
    logic [4:0]   btns;
    logic [1:0]   sel;
    logic [4:0]   pos;
    logic [3:0]   full;
    logic [127:0] lanes;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_clear, btn_lane, btn_back, btn_w1, btn_w0} = b;
  endtask

  // Hold for three edges (sync + edge detect + action), release, settle.
  task automatic press(input logic [4:0] b);
    set_btns(b);
    repeat (3) @(negedge clk);
    set_btns(B_NONE);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy_w === level) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int cnt;

    vecs[0]  = '{B_W1,         2'd0, 5'd1, 4'b0000, {LI, LI, LI, LD}};
    vecs[1]  = '{B_W0,         2'd0, 5'd2, 4'b0000, {LI, LI, LI, LD}};
    vecs[2]  = '{B_W1,         2'd0, 5'd3, 4'b0000, {LI, LI, LI, LD}};
    vecs[3]  = '{B_LANE,       2'd1, 5'd0, 4'b0000, {LI, LI, LI, LD}};
    vecs[4]  = '{B_W1,         2'd1, 5'd1, 4'b0000, {LI, LI, LD, LD}};
    vecs[5]  = '{B_LANE,       2'd2, 5'd0, 4'b0000, {LI, LI, LD, LD}};
    vecs[6]  = '{B_LANE,       2'd3, 5'd0, 4'b0000, {LI, LI, LD, LD}};
    vecs[7]  = '{B_LANE,       2'd0, 5'd3, 4'b0000, {LI, LI, LD, LD}};
    vecs[8]  = '{B_W1,         2'd0, 5'd4, 4'b0000, {LI, LI, LD, LD}};
    vecs[9]  = '{B_W1,         2'd0, 5'd5, 4'b0000, {LI, LI, LD, LDD}};
    vecs[10] = '{B_BACK,       2'd0, 5'd4, 4'b0000, {LI, LI, LD, LD}};
    vecs[11] = '{B_W0 | B_W1,  2'd0, 5'd4, 4'b0000, {LI, LI, LD, LD}};
    vecs[12] = '{B_LANE | B_W1, 2'd1, 5'd1, 4'b0000, {LI, LI, LD, LD}};
    vecs[13] = '{B_BACK | B_W0, 2'd1, 5'd0, 4'b0000, {LI, LI, LI, LD}};
    vecs[14] = '{B_BACK,       2'd1, 5'd0, 4'b0000, {LI, LI, LI, LD}};
    vecs[15] = '{B_LANE,       2'd2, 5'd0, 4'b0000, {LI, LI, LI, LD}};

    nrst = 1'b0;
    set_btns(B_NONE);
    repeat (3) @(negedge clk);
    check("rst_lanes", lanes_w, {LI, LI, LI, LI});
    check("rst_sel",   128'(sel_w), 128'd0);
    check("rst_pos",   128'(pos_w), 128'd0);
    check("rst_full",  128'(full_w), 128'd0);
    check("rst_busy",  128'(busy_w), 128'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single-button and coincident-button vectors.
    for (int i = 0; i < 16; i++) begin
      press(vecs[i].btns);
      check($sformatf("v%0d_sel", i),   128'(sel_w),  128'(vecs[i].sel));
      check($sformatf("v%0d_pos", i),   128'(pos_w),  128'(vecs[i].pos));
      check($sformatf("v%0d_full", i),  128'(full_w), 128'(vecs[i].full));
      check($sformatf("v%0d_lanes", i), lanes_w,      vecs[i].lanes);
      check($sformatf("v%0d_lanes_sat", i), lanes_s,  vecs[i].lanes);
    end

    // Fill lane 2 with 32 zeros: wrap vs saturate.
    for (int i = 0; i < 32; i++) press(B_W0);
    check("fill_lanes_w", lanes_w, {LI, LZ, LI, LD});
    check("fill_pos_w",   128'(pos_w), 128'd0);
    check("fill_full_w",  128'(full_w), 128'b0100);
    check("fill_lanes_s", lanes_s, {LI, LZ, LI, LD});
    check("fill_pos_s",   128'(pos_s), 128'd31);
    check("fill_full_s",  128'(full_s), 128'b0100);
    press(B_W1);
    check("wrap_w1_lanes", lanes_w, {LI, L1, LI, LD});
    check("wrap_w1_pos",   128'(pos_w), 128'd1);
    check("sat_w1_lanes",  lanes_s, {LI, LZ, LI, LD});
    check("sat_w1_pos",    128'(pos_s), 128'd31);

    // Clear sweep on lane 2 with a w1 pulse arriving mid-sweep.
    set_btns(B_CLEAR);
    wait_busy(1'b1, ok);
    check("clear_busy_rise", 128'(ok), 128'd1);
    cnt = 0;
    while (busy_w === 1'b1 && cnt < 100) begin
      if (cnt == 1) btn_clear = 1'b0;
      if (cnt == 3) btn_w1 = 1'b1;
      if (cnt == 6) btn_w1 = 1'b0;
      @(negedge clk);
      cnt++;
    end
    check("clear_busy_cycles", 128'(cnt), 128'd32);
    check("clear_busy_sat",  128'(busy_s), 128'd0);
    check("clear_lanes_w",   lanes_w, {LI, LI, LI, LD});
    check("clear_pos_w",     128'(pos_w), 128'd0);
    check("clear_full_w",    128'(full_w), 128'd0);
    check("clear_lanes_s",   lanes_s, {LI, LI, LI, LD});
    check("clear_pos_s",     128'(pos_s), 128'd0);
    repeat (4) @(negedge clk);

    // Reset during a sweep.
    press(B_W1);
    check("pre_rst_lanes", lanes_w, {LI, {LI[31:1], 1'b1}, LI, LD});
    set_btns(B_CLEAR);
    wait_busy(1'b1, ok);
    check("rst_clear_busy_rise", 128'(ok), 128'd1);
    set_btns(B_NONE);
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_busy",  128'(busy_w), 128'd0);
    check("midrst_lanes", lanes_w, {LI, LI, LI, LI});
    check("midrst_sel",   128'(sel_w), 128'd0);
    check("midrst_pos",   128'(pos_w), 128'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Clear and w1 together: clear wins, no write at lane 0 step 0.
    set_btns(B_CLEAR | B_W1);
    wait_busy(1'b1, ok);
    check("cw_busy_rise", 128'(ok), 128'd1);
    check("cw_pos",       128'(pos_w), 128'd0);
    check("cw_lane0",     128'(lanes_w[31:0]), 128'(LI));
    set_btns(B_NONE);
    wait_busy(1'b0, ok);
    check("cw_busy_fall", 128'(ok), 128'd1);
    check("cw_lanes",     lanes_w, {LI, LI, LI, LI});
    check("cw_full",      128'(full_w), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
